// File: rtl/spis_wb.sv
// SPI target (mode 0, MSB first) with a Wishbone register port.
// Define SPIS_RXFIFO_EN for a 4-entry RX FIFO instead of one holding register.
module spis_wb (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  // [0] sync1, [1] sync2, [2] history
  logic [2:0]  ss_q, sck_q, mosi_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [2:0]  bit_cnt_q;
  logic        byte_done_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_full_q, tx_full_d;
  logic        txu_q, txu_d;
  logic        ovr_q, ovr_d;

  logic        sel, ss_fall, ss_rise, sck_rise, sck_fall;
  logic        acc, rd, wr, pop, push, push_ok;
  logic        data_wr, stat_wr, tx_load;
  logic        rx_valid, rx_full;
  logic [7:0]  rx_head, rx_byte;
  logic [1:0]  adr;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4],
                       wb_adr_i[1:0], wb_dat_i[31:8]};

  assign sel      = ~ss_q[1];
  assign ss_fall  = ss_q[2] & ~ss_q[1];
  assign ss_rise  = ~ss_q[2] & ss_q[1];
  assign sck_rise = sel & sck_q[1] & ~sck_q[2];
  assign sck_fall = sel & ~sck_q[1] & sck_q[2];
  assign rx_byte  = {rx_shift_q[6:0], mosi_q[1]};

  assign adr     = wb_adr_i[3:2];
  assign acc     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign rd      = acc & ~wb_we_i;
  assign wr      = acc & wb_we_i;
  assign pop     = rd & (adr == 2'd0) & rx_valid;
  assign data_wr = wr & (adr == 2'd0);
  assign stat_wr = wr & (adr == 2'd1);
  assign push    = sck_rise & (bit_cnt_q == 3'd7);
  assign push_ok = push & (~rx_full | pop);
  assign tx_load = ss_fall | (sck_fall & byte_done_q);

  always_comb begin
    rdata = 32'h0;
    case (adr)
      2'd0:    rdata = {24'h0, rx_valid ? rx_head : 8'h00};
      2'd1:    rdata = {27'h0, txu_q, sel, tx_full_q,
                        ovr_q, rx_valid};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_data_d  = tx_data_q;
    tx_full_d  = tx_full_q;
    txu_d      = txu_q & ~(stat_wr & wb_dat_i[4]);
    ovr_d      = ovr_q & ~(stat_wr & wb_dat_i[1]);
    if (push & rx_full & ~pop) ovr_d = 1'b1;
    if (tx_load) begin
      tx_shift_d = tx_full_q ? tx_data_q : 8'hFF;
      txu_d      = txu_d | ~tx_full_q;
      tx_full_d  = 1'b0;
    end else if (sck_fall) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end
    // a CPU write beats a same-cycle consume
    if (data_wr) begin
      tx_data_d = wb_dat_i[7:0];
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ss_q        <= 3'b111;
      sck_q       <= 3'b000;
      mosi_q      <= 3'b000;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'hFF;
      tx_data_q   <= 8'h00;
      tx_full_q   <= 1'b0;
      txu_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ss_q       <= {ss_q[1:0], spi_ss};
      sck_q      <= {sck_q[1:0], spi_sck};
      mosi_q     <= {mosi_q[1:0], spi_mosi};
      ack_q      <= acc;
      dat_q      <= rd ? rdata : 32'h0;
      tx_shift_q <= tx_shift_d;
      tx_data_q  <= tx_data_d;
      tx_full_q  <= tx_full_d;
      txu_q      <= txu_d;
      ovr_q      <= ovr_d;
      if (ss_fall | ss_rise) begin
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
      end else if (sck_rise) begin
        rx_shift_q <= rx_byte;
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
      end else if (sck_fall) begin
        byte_done_q <= 1'b0;
      end
    end
  end

`ifdef SPIS_RXFIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q;

  assign rx_valid = (cnt_q != 3'd0);
  assign rx_full  = cnt_q[2];
  assign rx_head  = mem_q[rp_q];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (push_ok) wp_q <= wp_q + 2'd1;
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push_ok} - {2'b0, pop};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wp_q] <= rx_byte;
  end
`else
  logic [7:0] rx_q;
  logic       rv_q;

  assign rx_valid = rv_q;
  assign rx_full  = rv_q;
  assign rx_head  = rx_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_q <= 8'h00;
      rv_q <= 1'b0;
    end else if (push_ok) begin
      rx_q <= rx_byte;
      rv_q <= 1'b1;
    end else if (pop) begin
      rv_q <= 1'b0;
    end
  end
`endif

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = sel;
  assign irq         = rx_valid | ovr_q;

endmodule
